// File: rtl/cart_pkg.sv
// Shared types and defaults for the cartridge CPU-side bus logic.
package cart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StDecode,
      StRead,
      StDrive,
      StWaitFall,
      StWrite
   } cpu_state_t;

   localparam int unsigned SettleDefault = 2;

endpackage

// File: rtl/map_bus.sv
// Host <-> mapper bus: latched CPU cycle out, combinational decode back.
interface map_bus #(
   parameter int unsigned ADDR_BITS = 23
);
   logic [15:0]          cpu_addr;
   logic                 cpu_rw;
   logic [7:0]           cpu_data_in;
   logic                 cpu_wr_stb;
   logic [ADDR_BITS-1:0] prg_addr;
   logic                 prg_oe;
   logic                 prg_we;
   logic                 wram_ce;
   logic                 cpu_data_oe;
   logic [7:0]           cpu_data_out;

   modport host (
      output cpu_addr, cpu_rw, cpu_data_in, cpu_wr_stb,
      input  prg_addr, prg_oe, prg_we, wram_ce, cpu_data_oe, cpu_data_out
   );

   modport mapper (
      input  cpu_addr, cpu_rw, cpu_data_in, cpu_wr_stb,
      output prg_addr, prg_oe, prg_we, wram_ce, cpu_data_oe, cpu_data_out
   );
endinterface

// File: rtl/pin_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous cartridge pins.
module pin_sync #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/cart_cpu_bus.sv
// Tracks each NES M2 cycle, presents it to the mapper and turns the mapper's
// PRG/WRAM decode into single read/write requests toward the SDRAM arbiter.
module cart_cpu_bus
   import cart_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 23,
   parameter int unsigned SETTLE    = SettleDefault
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 m2,
   input  logic [15:0]          cpu_addr_pin,
   input  logic                 cpu_rw_pin,
   input  logic [7:0]           cpu_data_pin,
   output logic [7:0]           cpu_data_out,
   output logic                 cpu_data_drive,
   map_bus.host                 bus,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_rdata,
   output logic                 miss
);

   localparam int unsigned CntW = (SETTLE > 2) ? $clog2(SETTLE) : 1;

   logic        m2_s;
   logic [16:0] ar_s;
   logic [7:0]  data_s;
   logic        m2_rise;

   cpu_state_t           state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 m2_q;
   logic [15:0]          cpu_addr_q, cpu_addr_d;
   logic                 cpu_rw_q, cpu_rw_d;
   logic [7:0]           cap_q, cap_d;
   logic [7:0]           data_in_q, data_in_d;
   logic                 wr_stb_q, wr_stb_d;
   logic [7:0]           data_out_q, data_out_d;
   logic                 drive_q, drive_d;
   logic                 req_q, req_d;
   logic                 we_q, we_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 miss_q, miss_d;

   pin_sync #(.Width(1)) u_sync_m2 (
      .clk_i   (clk),
      .reset_i (reset),
      .d_i     (m2),
      .q_o     (m2_s)
   );

   pin_sync #(.Width(17)) u_sync_ar (
      .clk_i   (clk),
      .reset_i (reset),
      .d_i     ({cpu_rw_pin, cpu_addr_pin}),
      .q_o     (ar_s)
   );

   pin_sync #(.Width(8)) u_sync_data (
      .clk_i   (clk),
      .reset_i (reset),
      .d_i     (cpu_data_pin),
      .q_o     (data_s)
   );

   assign m2_rise = m2_s & ~m2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         m2_q       <= 1'b0;
         cpu_addr_q <= 16'h0000;
         cpu_rw_q   <= 1'b1;
         cap_q      <= 8'h00;
         data_in_q  <= 8'h00;
         wr_stb_q   <= 1'b0;
         data_out_q <= 8'h00;
         drive_q    <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 8'h00;
         miss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         m2_q       <= m2_s;
         cpu_addr_q <= cpu_addr_d;
         cpu_rw_q   <= cpu_rw_d;
         cap_q      <= cap_d;
         data_in_q  <= data_in_d;
         wr_stb_q   <= wr_stb_d;
         data_out_q <= data_out_d;
         drive_q    <= drive_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         miss_q     <= miss_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cpu_addr_d = cpu_addr_q;
      cpu_rw_d   = cpu_rw_q;
      cap_d      = cap_q;
      data_in_d  = data_in_q;
      wr_stb_d   = 1'b0;
      data_out_d = data_out_q;
      drive_d    = drive_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      miss_d     = 1'b0;

      // A new CPU cycle started before the previous one was retired.
      if (m2_rise && state_q != StIdle) miss_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (m2_rise) begin
               if (SETTLE == 0) begin
                  cpu_addr_d = ar_s[15:0];
                  cpu_rw_d   = ar_s[16];
                  state_d    = StDecode;
               end else begin
                  cnt_d   = CntW'(SETTLE - 1);
                  state_d = StSettle;
               end
            end
         end
         StSettle: begin
            if (cnt_q == '0) begin
               cpu_addr_d = ar_s[15:0];
               cpu_rw_d   = ar_s[16];
               state_d    = StDecode;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDecode: begin
            if (cpu_rw_q && bus.cpu_data_oe) begin
               data_out_d = bus.cpu_data_out;
               drive_d    = 1'b1;
               state_d    = StDrive;
            end else if (cpu_rw_q && (bus.prg_oe || bus.wram_ce)) begin
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = bus.prg_addr;
               state_d = StRead;
            end else begin
               state_d = StWaitFall;
            end
         end
         StRead: begin
            if (mem_ack) begin
               data_out_d = mem_rdata;
               req_d      = 1'b0;
               if (m2_s) begin
                  drive_d = 1'b1;
                  state_d = StDrive;
               end else begin
                  miss_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StDrive: begin
            if (!m2_s) begin
               drive_d = 1'b0;
               state_d = StIdle;
            end
         end
         StWaitFall: begin
            if (m2_s) begin
               cap_d = data_s;
            end else begin
               data_in_d = cap_q;
               state_d   = StIdle;
               if (!cpu_rw_q) begin
                  wr_stb_d = 1'b1;
                  if (bus.prg_we || bus.wram_ce) begin
                     req_d   = 1'b1;
                     we_d    = 1'b1;
                     addr_d  = bus.prg_addr;
                     wdata_d = cap_q;
                     state_d = StWrite;
                  end
               end
            end
         end
         StWrite: begin
            if (mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.cpu_addr    = cpu_addr_q;
   assign bus.cpu_rw      = cpu_rw_q;
   assign bus.cpu_data_in = data_in_q;
   assign bus.cpu_wr_stb  = wr_stb_q;
   assign cpu_data_out    = data_out_q;
   assign cpu_data_drive  = drive_q;
   assign mem_req         = req_q;
   assign mem_we          = we_q;
   assign mem_addr        = addr_q;
   assign mem_wdata       = wdata_q;
   assign miss            = miss_q;

endmodule

// File: tb/tb_cart_cpu_bus.sv
// Directed bench for cart_cpu_bus with a small NROM-style mapper model.
module tb_cart_cpu_bus;
   import cart_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        m2;
   logic [15:0] cpu_addr_pin;
   logic        cpu_rw_pin;
   logic [7:0]  cpu_data_pin;
   logic [7:0]  cpu_data_out;
   logic        cpu_data_drive;
   logic        mem_req;
   logic        mem_we;
   logic [22:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        miss;

   int checks = 0;
   int errors = 0;
   int n;
   int stb_cnt = 0, req_cnt = 0, miss_cnt = 0, drv_cnt = 0;
   int stb_b, req_b, miss_b, drv_b;
   logic req_prev = 1'b0;

   map_bus #(.ADDR_BITS(23)) bus_if ();

   // NROM: 32K PRG mirrored from $8000, WRAM at $6000-$7FFF, one register at $4020.
   assign bus_if.prg_addr     = {8'h00, bus_if.cpu_addr[14:0]};
   assign bus_if.prg_oe       = bus_if.cpu_rw & bus_if.cpu_addr[15];
   assign bus_if.prg_we       = 1'b0;
   assign bus_if.wram_ce      = (bus_if.cpu_addr[15:13] == 3'b011);
   assign bus_if.cpu_data_oe  = bus_if.cpu_rw && (bus_if.cpu_addr == 16'h4020);
   assign bus_if.cpu_data_out = 8'hC3;

   cart_cpu_bus #(.ADDR_BITS(23), .SETTLE(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .m2             (m2),
      .cpu_addr_pin   (cpu_addr_pin),
      .cpu_rw_pin     (cpu_rw_pin),
      .cpu_data_pin   (cpu_data_pin),
      .cpu_data_out   (cpu_data_out),
      .cpu_data_drive (cpu_data_drive),
      .bus            (bus_if),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .miss           (miss)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_if.cpu_wr_stb) stb_cnt++;
      if (miss) miss_cnt++;
      if (cpu_data_drive) drv_cnt++;
      if (mem_req && !req_prev) req_cnt++;
      req_prev = mem_req;
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      stb_b  = stb_cnt;
      req_b  = req_cnt;
      miss_b = miss_cnt;
      drv_b  = drv_cnt;
   endtask

   initial begin
      reset = 1'b1; m2 = 1'b0; cpu_addr_pin = 16'h0000; cpu_rw_pin = 1'b1;
      cpu_data_pin = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst_req",      32'(mem_req), 32'd0);
      chk("rst_we",       32'(mem_we), 32'd0);
      chk("rst_drive",    32'(cpu_data_drive), 32'd0);
      chk("rst_miss",     32'(miss), 32'd0);
      chk("rst_stb",      32'(bus_if.cpu_wr_stb), 32'd0);
      chk("rst_dout",     32'(cpu_data_out), 32'h00);
      chk("rst_wdata",    32'(mem_wdata), 32'h00);
      chk("rst_din",      32'(bus_if.cpu_data_in), 32'h00);
      chk("rst_cpu_addr", 32'(bus_if.cpu_addr), 32'h0000);
      chk("rst_cpu_rw",   32'(bus_if.cpu_rw), 32'd1);

      // Read $8123, ack 4 clk after request with 0x5A.
      snap();
      cpu_addr_pin = 16'h8123; cpu_rw_pin = 1'b1; m2 = 1'b1;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin tick(1); n++; end
      chk("rd_latency",  32'(n), 32'd6);
      chk("rd_addr",     32'(mem_addr), 32'h0123);
      chk("rd_we",       32'(mem_we), 32'd0);
      chk("rd_cpu_addr", 32'(bus_if.cpu_addr), 32'h8123);
      tick(3);
      chk("rd_hold_req",  32'(mem_req), 32'd1);
      chk("rd_hold_addr", 32'(mem_addr), 32'h0123);
      mem_rdata = 8'h5A; mem_ack = 1'b1;
      tick(1);
      mem_ack = 1'b0;
      chk("rd_drive", 32'(cpu_data_drive), 32'd1);
      chk("rd_dout",  32'(cpu_data_out), 32'h5A);
      chk("rd_req_drop", 32'(mem_req), 32'd0);
      tick(2);
      m2 = 1'b0;
      tick(2);
      chk("rd_drive_hold", 32'(cpu_data_drive), 32'd1);
      tick(1);
      chk("rd_drive_off", 32'(cpu_data_drive), 32'd0);
      chk("rd_no_miss", 32'(miss_cnt - miss_b), 32'd0);
      tick(3);

      // Write 0x77 to WRAM at $6010.
      snap();
      cpu_addr_pin = 16'h6010; cpu_rw_pin = 1'b0; cpu_data_pin = 8'h77; m2 = 1'b1;
      tick(12);
      chk("wr_no_early_req", 32'(mem_req), 32'd0);
      m2 = 1'b0;
      tick(3);
      chk("wr_stb",   32'(bus_if.cpu_wr_stb), 32'd1);
      chk("wr_din",   32'(bus_if.cpu_data_in), 32'h77);
      chk("wr_req",   32'(mem_req), 32'd1);
      chk("wr_we",    32'(mem_we), 32'd1);
      chk("wr_wdata", 32'(mem_wdata), 32'h77);
      chk("wr_addr",  32'(mem_addr), 32'h6010);
      tick(1);
      chk("wr_stb_once", 32'(bus_if.cpu_wr_stb), 32'd0);
      chk("wr_req_held", 32'(mem_req), 32'd1);
      mem_ack = 1'b1;
      tick(1);
      mem_ack = 1'b0;
      chk("wr_req_drop", 32'(mem_req), 32'd0);
      tick(2);
      chk("wr_stb_count", 32'(stb_cnt - stb_b), 32'd1);
      chk("wr_req_count", 32'(req_cnt - req_b), 32'd1);
      chk("wr_no_drive",  32'(drv_cnt - drv_b), 32'd0);

      // Write to ROM at $8000: strobe only.
      snap();
      cpu_addr_pin = 16'h8000; cpu_rw_pin = 1'b0; cpu_data_pin = 8'h12; m2 = 1'b1;
      tick(12);
      m2 = 1'b0;
      tick(3);
      chk("rom_wr_stb", 32'(bus_if.cpu_wr_stb), 32'd1);
      chk("rom_wr_din", 32'(bus_if.cpu_data_in), 32'h12);
      chk("rom_wr_req", 32'(mem_req), 32'd0);
      tick(3);
      chk("rom_wr_stb_count", 32'(stb_cnt - stb_b), 32'd1);
      chk("rom_wr_req_count", 32'(req_cnt - req_b), 32'd0);

      // Read $8200 with ack withheld past M2 fall.
      snap();
      cpu_addr_pin = 16'h8200; cpu_rw_pin = 1'b1; m2 = 1'b1;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin tick(1); n++; end
      chk("late_latency", 32'(n), 32'd6);
      chk("late_addr", 32'(mem_addr), 32'h0200);
      tick(4);
      m2 = 1'b0;
      tick(5);
      mem_rdata = 8'h99; mem_ack = 1'b1;
      tick(1);
      mem_ack = 1'b0;
      chk("late_miss",  32'(miss), 32'd1);
      chk("late_drive", 32'(cpu_data_drive), 32'd0);
      chk("late_req",   32'(mem_req), 32'd0);
      chk("late_dout",  32'(cpu_data_out), 32'h99);
      tick(1);
      chk("late_miss_once", 32'(miss), 32'd0);
      chk("late_idle", 32'(dut.state_q), 32'(StIdle));
      chk("late_miss_count",  32'(miss_cnt - miss_b), 32'd1);
      chk("late_drive_count", 32'(drv_cnt - drv_b), 32'd0);
      tick(2);

      // Reset while a read request is outstanding.
      cpu_addr_pin = 16'h8004; cpu_rw_pin = 1'b1; m2 = 1'b1;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin tick(1); n++; end
      chk("rr_req_up", 32'(mem_req), 32'd1);
      reset = 1'b1; m2 = 1'b0;
      tick(1);
      chk("rr_req",      32'(mem_req), 32'd0);
      chk("rr_we",       32'(mem_we), 32'd0);
      chk("rr_drive",    32'(cpu_data_drive), 32'd0);
      chk("rr_miss",     32'(miss), 32'd0);
      chk("rr_dout",     32'(cpu_data_out), 32'h00);
      chk("rr_wdata",    32'(mem_wdata), 32'h00);
      chk("rr_din",      32'(bus_if.cpu_data_in), 32'h00);
      chk("rr_cpu_addr", 32'(bus_if.cpu_addr), 32'h0000);
      chk("rr_cpu_rw",   32'(bus_if.cpu_rw), 32'd1);
      tick(2);
      reset = 1'b0;
      tick(2);
      cpu_addr_pin = 16'h8005; m2 = 1'b1;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin tick(1); n++; end
      chk("rr2_latency", 32'(n), 32'd6);
      chk("rr2_addr", 32'(mem_addr), 32'h0005);
      mem_rdata = 8'h3C; mem_ack = 1'b1;
      tick(1);
      mem_ack = 1'b0;
      chk("rr2_drive", 32'(cpu_data_drive), 32'd1);
      chk("rr2_dout",  32'(cpu_data_out), 32'h3C);
      tick(2);
      m2 = 1'b0;
      tick(3);
      chk("rr2_drive_off", 32'(cpu_data_drive), 32'd0);
      tick(2);

      // Mapper register read at $4020 drives 0xC3 without memory traffic.
      snap();
      cpu_addr_pin = 16'h4020; cpu_rw_pin = 1'b1; m2 = 1'b1;
      n = 0;
      while (cpu_data_drive !== 1'b1 && n < 20) begin tick(1); n++; end
      chk("reg_latency", 32'(n), 32'd6);
      chk("reg_dout", 32'(cpu_data_out), 32'hC3);
      tick(3);
      chk("reg_drive_hold", 32'(cpu_data_drive), 32'd1);
      m2 = 1'b0;
      tick(3);
      chk("reg_drive_off", 32'(cpu_data_drive), 32'd0);
      chk("reg_no_req",  32'(req_cnt - req_b), 32'd0);
      chk("reg_no_miss", 32'(miss_cnt - miss_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
